fp_log2_seq: RTL and testbench

//   Sequential IEEE-754 single-precision base-2 logarithm: y = log2(x). Inverse of
//   EXP_REAL (base^exp); the nroot/pow path uses it to form exp*log2(base). Bit-serial

---
 rtl/fp_log2_seq.sv | 188 ++++++++++++++++++
 tb/tb_fp_log2_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fp_log2_seq.sv
// Sequential single-precision log2: integer exponent plus a bit-serial squaring loop
// that yields one fraction bit of log2(mantissa) per cycle, packed back to IEEE-754.
module fp_log2_seq #(
  parameter int FRAC_BITS = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  localparam int CW = $clog2(FRAC_BITS);
  localparam int RW = FRAC_BITS + 10;
  localparam int SW = RW + 23;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAC_BITS - 1);
  localparam logic [5:0]    TOP6     = 6'(RW - 1);
  localparam logic [7:0]    FB8      = 8'(FRAC_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic [CW-1:0]          cnt_r;
  logic [8:0]             e_r;
  logic [23:0]            m_r;
  logic [FRAC_BITS-1:0]   f_r;
  logic [31:0]            y_r;
  logic                   in_ready_r;
  logic                   out_valid_r;

  logic                   special_s;
  logic [31:0]            special_y_s;
  logic [24:0]            sq_hi_s;
  logic                   bit_s;
  logic [23:0]            m_next_s;
  logic [RW-1:0]          r_s;
  logic [RW-1:0]          mag_s;
  logic [5:0]             lead_s;
  logic [SW-1:0]          shl_s;
  logic [7:0]             pexp_s;
  logic [22:0]            mant_s;
  logic [31:0]            pack_y_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign y         = y_r;

  // Classify the incoming operand; zero/denormal is checked first so -0 and -denormal give -inf.
  always_comb begin
    special_s   = 1'b1;
    special_y_s = 32'h0000_0000;
    if (x_in[30:23] == 8'h00) begin
      special_y_s = 32'hFF80_0000;
    end else if ((x_in[30:23] == 8'hFF) && (x_in[22:0] != 23'h0)) begin
      special_y_s = 32'h7FC0_0000;
    end else if (x_in[31]) begin
      special_y_s = 32'h7FC0_0000;
    end else if (x_in[30:23] == 8'hFF) begin
      special_y_s = 32'h7F80_0000;
    end else if (x_in[30:0] == 31'h3F80_0000) begin
      special_y_s = 32'h0000_0000;
    end else begin
      special_s   = 1'b0;
      special_y_s = 32'h0000_0000;
    end
  end

  // One squaring step: a product >= 2 emits a 1 and renormalises by halving.
  always_comb begin
    sq_hi_s = 25'(({24'h00_0000, m_r} * {24'h00_0000, m_r}) >> 23);
    bit_s   = sq_hi_s[24];
    if (bit_s) begin
      m_next_s = sq_hi_s[24:1];
    end else begin
      m_next_s = sq_hi_s[23:0];
    end
  end

  // Fixed-point result R = e*2^FRAC_BITS + f (two's complement) converted to single precision.
  always_comb begin
    r_s = ({{(RW-9){e_r[8]}}, e_r} << FRAC_BITS) + {{(RW-FRAC_BITS){1'b0}}, f_r};
    if (r_s[RW-1]) begin
      mag_s = ~r_s + {{(RW-1){1'b0}}, 1'b1};
    end else begin
      mag_s = r_s;
    end
    lead_s = 6'd0;
    for (int i = 0; i < RW; i++) begin
      if (mag_s[i]) begin
        lead_s = 6'(i);
      end else begin
        lead_s = lead_s;
      end
    end
    shl_s  = {mag_s, 23'h00_0000} << (TOP6 - lead_s);
    mant_s = 23'(shl_s >> (RW - 1));
    pexp_s = 8'd127 + {2'b00, lead_s} - FB8;
    if (|mag_s) begin
      pack_y_s = {r_s[RW-1], pexp_s, mant_s};
    end else begin
      pack_y_s = 32'h0000_0000;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = special_s ? DONE : ITER;
        end else begin
          state_s = IDLE;
        end
      end
      ITER: begin
        if (cnt_r == CNT_LAST) begin
          state_s = PACK;
        end else begin
          state_s = ITER;
        end
      end
      PACK: state_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Datapath: operand capture, iteration, and result update on the way into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
      e_r   <= 9'd0;
      m_r   <= 24'd0;
      f_r   <= {FRAC_BITS{1'b0}};
      y_r   <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            cnt_r <= {CW{1'b0}};
            e_r   <= {1'b0, x_in[30:23]} - 9'd127;
            m_r   <= {1'b1, x_in[22:0]};
            f_r   <= {FRAC_BITS{1'b0}};
            if (special_s) begin
              y_r <= special_y_s;
            end
          end
        end
        ITER: begin
          m_r   <= m_next_s;
          f_r   <= {f_r[FRAC_BITS-2:0], bit_s};
          cnt_r <= cnt_r + CW'(1);
        end
        PACK: y_r <= pack_y_s;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_log2_seq.sv
// Directed and randomized checks of fp_log2_seq against an integer repeated-squaring
// reference of log2, including latency, backpressure and mid-operation reset.
module tb_fp_log2_seq;

  localparam int FB = 23;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] x_in = 32'h0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] y;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_log2_seq #(.FRAC_BITS(FB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  function automatic bit ref_special(input logic [31:0] x);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) || x[31] || (x == 32'h3F80_0000);
  endfunction

  // log2(x) = (exp-127) + log2(mantissa); fraction bits come from repeated squaring.
  function automatic logic [31:0] ref_log2(input logic [31:0] x);
    longint m, p, f, r, mag;
    int k;
    logic [7:0] be;
    logic [22:0] mt;
    if (x[30:23] == 8'h00) return 32'hFF80_0000;
    if ((x[30:23] == 8'hFF) && (x[22:0] != 23'h0)) return 32'h7FC0_0000;
    if (x[31]) return 32'h7FC0_0000;
    if (x[30:23] == 8'hFF) return 32'h7F80_0000;
    if (x == 32'h3F80_0000) return 32'h0000_0000;
    m = longint'({1'b1, x[22:0]});
    f = 64'sd0;
    for (int i = 0; i < FB; i++) begin
      p = m * m;
      if (p >= (64'sd1 <<< 47)) begin
        f = f * 64'sd2 + 64'sd1;
        m = p >>> 24;
      end else begin
        f = f * 64'sd2;
        m = p >>> 23;
      end
    end
    r = longint'(int'(x[30:23]) - 127) * (64'sd1 <<< FB) + f;
    if (r == 64'sd0) return 32'h0000_0000;
    mag = (r < 64'sd0) ? -r : r;
    k = 0;
    while ((mag >>> (k + 1)) != 64'sd0) k++;
    be = 8'(127 + k - FB);
    mt = 23'(((mag - (64'sd1 <<< k)) <<< 23) >>> k);
    return {(r < 64'sd0), be, mt};
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  // Issue one operand with out_ready=1, measure latency, check result and return to idle.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] yexp,
                        input int lat_exp, output logic [31:0] yobs);
    int lat;
    @(negedge clk);
    check32({tag, " in_ready_before"}, {31'h0, in_ready}, 32'd1);
    in_valid = 1'b1;
    x_in     = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_in     = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check32({tag, " in_ready_busy"}, {31'h0, in_ready}, 32'd0);
    end while (!out_valid && lat < 200);
    check32({tag, " latency"}, 32'(lat), 32'(lat_exp));
    check32({tag, " y"}, y, yexp);
    yobs = y;
    @(negedge clk);
    check32({tag, " idle_after"}, {30'h0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] yo;
    logic [31:0] x;
    logic [31:0] yhold;
    int lat;

    repeat (2) @(negedge clk);
    check32("reset in_ready", {31'h0, in_ready}, 32'd1);
    check32("reset out_valid", {31'h0, out_valid}, 32'd0);
    check32("reset y", y, 32'h0);
    rst_n = 1'b1;

    run_op("eight", 32'h4100_0000, 32'h4040_0000, FB + 2, yo);
    run_op("half", 32'h3F00_0000, 32'hBF80_0000, FB + 2, yo);
    run_op("one", 32'h3F80_0000, 32'h0000_0000, 1, yo);
    run_op("thousand", 32'h447A_0000, ref_log2(32'h447A_0000), FB + 2, yo);
    total++;
    assert ((yo <= 32'h411F_73DA) && (yo >= 32'h411F_73D8)) else begin
      bad++;
      $error("FAIL thousand_ulp: observed=%08h expected within 2 ulp below 411f73da", yo);
    end
    run_op("zero", 32'h0000_0000, 32'hFF80_0000, 1, yo);
    run_op("negzero", 32'h8000_0000, 32'hFF80_0000, 1, yo);
    run_op("denorm", 32'h0000_1234, 32'hFF80_0000, 1, yo);
    run_op("negone", 32'hBF80_0000, 32'h7FC0_0000, 1, yo);
    run_op("pinf", 32'h7F80_0000, 32'h7F80_0000, 1, yo);
    run_op("nan", 32'h7FC0_0001, 32'h7FC0_0000, 1, yo);
    run_op("tiny", 32'h0080_0000, ref_log2(32'h0080_0000), FB + 2, yo);
    run_op("huge", 32'h7F7F_FFFF, ref_log2(32'h7F7F_FFFF), FB + 2, yo);

    // Backpressure: result must hold and new operands must be ignored.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = 32'h4100_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    check32("bp latency", 32'(lat), 32'(FB + 2));
    check32("bp y", y, 32'h4040_0000);
    yhold = y;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      x_in     = $urandom;
      @(negedge clk);
      check32($sformatf("bp hold%0d", i), {30'h0, out_valid, in_ready}, 32'd2);
      check32($sformatf("bp y%0d", i), y, yhold);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check32("bp release", {30'h0, out_valid, in_ready}, 32'd1);
    run_op("after_bp", 32'h3F00_0000, 32'hBF80_0000, FB + 2, yo);

    // Reset during iteration aborts the operation.
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = 32'h4100_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check32("midrst outputs", {30'h0, out_valid, in_ready}, 32'd1);
    check32("midrst y", y, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check32("midrst no_result", {30'h0, out_valid, in_ready}, 32'd1);
    run_op("after_rst", 32'h4100_0000, 32'h4040_0000, FB + 2, yo);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      end else begin
        x = $urandom;
      end
      run_op($sformatf("rnd%0d_%08h", i, x), x, ref_log2(x), ref_special(x) ? 1 : FB + 2, yo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
